flash_prog_ctrl: RTL

- Write-side companion to the flash read controller. Programs one 16-bit word into the board's parallel NOR flash, or erases one block, using the Intel/StrataFlash command set.
- Sequence per operation: command write, data/confirm write, status-register polling, then a restore to read-array mode (0x00FF) so the read controller can run afterwards without extra setup.
- Sits between the boot/loader logic and the flash pins. Shares the flash bus with the read controller through an external mux; only one controller is active at a time.

---
 rtl/flash_prog_ctrl_if.sv | 31 +++
 rtl/flash_prog_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/flash_prog_ctrl_if.sv
// ============================================================================
//  Module      : flash_prog_ctrl_if
//  Description : Request/result bundle between loader logic and the flash
//                program/erase controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface flash_prog_ctrl_if;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic        op_erase;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic        timeout;
    logic [7:0]  status_reg;

    modport master (
        output addr, wdata, op_erase, start,
        input  busy, done, error, timeout, status_reg
    );

    modport slave (
        input  addr, wdata, op_erase, start,
        output busy, done, error, timeout, status_reg
    );
endinterface

`default_nettype wire

// File: rtl/flash_prog_ctrl.sv
// ============================================================================
//  Module      : flash_prog_ctrl
//  Description : Word program / block erase sequencer for Intel-command-set
//                parallel NOR flash, ending in read-array mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_prog_ctrl #(
    parameter int CLK_DIV  = 8,
    parameter int POLL_MAX = 65535
) (
    input  wire logic         clk,
    input  wire logic         rst,
    flash_prog_ctrl_if.slave  bus,
    output logic [22:0]       flash_addr,
    inout  wire  [15:0]       flash_data,
    output logic              flash_byte,
    output logic              flash_vpen,
    output logic              flash_rp,
    output logic              flash_ce,
    output logic              flash_oe,
    output logic              flash_we
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CMD     = 3'd1;
    localparam logic [2:0] S_DATA    = 3'd2;
    localparam logic [2:0] S_POLL    = 3'd3;
    localparam logic [2:0] S_CLEAR   = 3'd4;
    localparam logic [2:0] S_RESTORE = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;

    localparam logic [1:0] PH_SETUP = 2'd0;
    localparam logic [1:0] PH_MID   = 2'd1;
    localparam logic [1:0] PH_LAST  = 2'd2;

    logic [2:0]    r_state;
    logic [1:0]    r_phase;
    logic [CW-1:0] r_cnt;
    logic [21:0]   r_addr;
    logic [15:0]   r_wdata;
    logic          r_erase;
    logic [15:0]   r_poll;
    logic          r_busy;
    logic          r_done;
    logic          r_error;
    logic          r_timeout;
    logic [7:0]    r_status;

    logic [2:0]    w_next;
    logic          w_in_bus;
    logic          w_phase_end;
    logic          w_bus_end;
    logic          w_is_write;
    logic          w_is_read;
    logic          w_drive;
    logic [15:0]   w_wr_word;
    logic [7:0]    w_rd_byte;
    logic          w_st_err;
    logic          w_poll_last;
    logic          w_unused_hi;

    assign w_rd_byte   = flash_data[7:0];
    assign w_unused_hi = ^flash_data[15:8];
    assign w_st_err    = w_rd_byte[5] | w_rd_byte[4] | w_rd_byte[3] | w_rd_byte[1];
    // This read is the POLL_MAX-th one when the count before it is POLL_MAX-1.
    assign w_poll_last = ({1'b0, r_poll} + 17'd1) >= 17'(POLL_MAX);

    assign w_in_bus    = (r_state == S_CMD) || (r_state == S_DATA) || (r_state == S_POLL) ||
                         (r_state == S_CLEAR) || (r_state == S_RESTORE);
    assign w_phase_end = (r_cnt == CW'(CLK_DIV - 1));
    assign w_bus_end   = w_phase_end && (r_phase == PH_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (bus.start) w_next = S_CMD;
            S_CMD:     if (w_bus_end) w_next = S_DATA;
            S_DATA:    if (w_bus_end) w_next = S_POLL;
            S_POLL: begin
                if (w_bus_end) begin
                    if (w_rd_byte[7])     w_next = w_st_err ? S_CLEAR : S_RESTORE;
                    else if (w_poll_last) w_next = S_RESTORE;
                    else                  w_next = S_POLL;
                end
            end
            S_CLEAR:   if (w_bus_end) w_next = S_RESTORE;
            S_RESTORE: if (w_bus_end) w_next = S_FIN;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_is_write = (r_state == S_CMD) || (r_state == S_DATA) ||
                     (r_state == S_CLEAR) || (r_state == S_RESTORE);
        w_is_read  = (r_state == S_POLL);
        w_drive    = w_is_write;
        flash_we   = !(w_is_write && (r_phase == PH_MID));
        flash_oe   = !(w_is_read && (r_phase != PH_SETUP));
        case (r_state)
            S_CMD:   w_wr_word = r_erase ? 16'h0020 : 16'h0040;
            S_DATA:  w_wr_word = r_erase ? 16'h00D0 : r_wdata;
            S_CLEAR: w_wr_word = 16'h0050;
            default: w_wr_word = 16'h00FF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_phase <= PH_SETUP;
            r_cnt   <= '0;
        end else if (!w_in_bus) begin
            r_phase <= PH_SETUP;
            r_cnt   <= '0;
        end else if (w_phase_end) begin
            r_cnt   <= '0;
            r_phase <= (r_phase == PH_LAST) ? PH_SETUP : r_phase + 2'd1;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_erase   <= 1'b0;
            r_poll    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
            r_status  <= '0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == S_IDLE) && bus.start) begin
                r_addr    <= bus.addr;
                r_wdata   <= bus.wdata;
                r_erase   <= bus.op_erase;
                r_poll    <= '0;
                r_error   <= 1'b0;
                r_timeout <= 1'b0;
                r_busy    <= 1'b1;
            end
            // Status byte is sampled on the final clk of the OE2 phase.
            if ((r_state == S_POLL) && w_bus_end) begin
                r_status <= w_rd_byte;
                r_poll   <= r_poll + 16'd1;
                if (w_rd_byte[7]) begin
                    r_error <= w_st_err;
                end else if (w_poll_last) begin
                    r_error   <= 1'b1;
                    r_timeout <= 1'b1;
                end
            end
            if (r_state == S_FIN) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign flash_data     = w_drive ? w_wr_word : 16'hzzzz;
    assign flash_addr     = {r_addr, 1'b0};
    assign flash_byte     = 1'b1;
    assign flash_vpen     = 1'b1;
    assign flash_rp       = 1'b1;
    assign flash_ce       = 1'b0;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.error      = r_error;
    assign bus.timeout    = r_timeout;
    assign bus.status_reg = r_status;

endmodule

`default_nettype wire
